// File: rtl/td4_program_sequencer.sv
// Program store and execution sequencer for the 4-bit TD4 core: host byte loader,
// core reset release, and run/step/pause clock-enable generation with stop detection.
module td4_program_sequencer #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned DIV_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       run,
    input  logic       step,
    input  logic       halt,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] cpu_address,
    output logic [7:0] cpu_instr,
    output logic       cpu_tick,
    output logic       cpu_n_reset,
    output logic [1:0] state,
    output logic       loop_stop
);

    localparam int unsigned    DEPTH    = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_ptr;
    logic [7:0]       r_mem [DEPTH];
    logic [DIV_W-1:0] r_div;
    logic             r_first;
    logic             r_loop_stop;

    logic w_cand;
    logic w_self;
    logic w_bp;
    logic w_run_tick;
    logic w_step_tick;

    assign cpu_instr   = r_mem[cpu_address];
    assign load_ready  = (r_state == ST_LOAD);
    assign cpu_n_reset = (r_state != ST_LOAD);
    assign state       = r_state;
    assign loop_stop   = r_loop_stop;

    // Stop conditions evaluated on RUN tick candidates; breakpoint skipped on the first one
    always_comb begin
        w_cand      = 1'b0;
        w_self      = 1'b0;
        w_bp        = 1'b0;
        w_run_tick  = 1'b0;
        w_step_tick = 1'b0;
        w_cand      = (r_state == ST_RUN) && (r_div == DIV_LAST);
        w_self      = (cpu_instr == {4'b1111, cpu_address});
        w_bp        = bp_en && (cpu_address == bp_addr) && !r_first;
        w_run_tick  = w_cand && !halt && !w_self && !w_bp && run;
        w_step_tick = (r_state == ST_PAUSE) && step && !halt;
    end

    assign cpu_tick = !reset && !load_start && (w_run_tick || w_step_tick);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_ptr       <= 4'd0;
            r_mem       <= '{default: 8'h00};
            r_div       <= '0;
            r_first     <= 1'b0;
            r_loop_stop <= 1'b0;
        end else if (load_start) begin
            r_state     <= ST_LOAD;
            r_ptr       <= 4'd0;
            r_div       <= '0;
            r_first     <= 1'b0;
            r_loop_stop <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (load_valid) begin
                        r_mem[r_ptr] <= load_data;
                        r_ptr        <= r_ptr + 4'd1;
                        if (r_ptr == 4'd15) begin
                            r_state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (run && !halt) begin
                        r_state <= ST_RUN;
                        r_div   <= '0;
                        r_first <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        r_state <= ST_PAUSE;
                        r_div   <= '0;
                    end else if (w_cand) begin
                        r_div   <= '0;
                        r_first <= 1'b0;
                        if (w_self) begin
                            r_loop_stop <= 1'b1;
                            r_state     <= ST_PAUSE;
                        end else if (w_bp || !run) begin
                            r_state <= ST_PAUSE;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
